// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_packer
// Brief    : Packs a byte stream into little-endian words and emits each word
//            with a one-cycle enable. Optional flush of a partial word is
//            enabled by defining BYTE_WORD_PACKER_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_packer #(
    parameter int          WORD_BYTES = 4,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [7:0]                      byte_i,
    input  logic                            byte_valid_i,
    input  logic                            flush_i,
    output logic [8*WORD_BYTES-1:0]         word_o,
    output logic                            word_en_o,
    output logic [$clog2(WORD_BYTES+1)-1:0] valid_bytes_o,
    output logic [$clog2(WORD_BYTES)-1:0]   fill_o
);

    localparam int CW = $clog2(WORD_BYTES);
    localparam int VW = $clog2(WORD_BYTES + 1);

    logic [CW-1:0]           cnt;
    logic [8*WORD_BYTES-1:0] acc;
    logic [8*WORD_BYTES-1:0] merged;
    logic                    last;
    logic                    emit;
    logic [8*WORD_BYTES-1:0] emit_word;
    logic [VW-1:0]           emit_vb;

    // Accumulator with this cycle's byte (if any) dropped into lane cnt.
    always_comb begin
        merged = acc;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (byte_valid_i && (cnt == CW'(k))) begin
                merged[8*k +: 8] = byte_i;
            end
        end
    end

    assign last = byte_valid_i && (cnt == CW'(WORD_BYTES - 1));

`ifdef BYTE_WORD_PACKER_FLUSH_EN
    logic [VW-1:0]           cnt_after;
    logic                    do_flush;
    logic [8*WORD_BYTES-1:0] padded;

    assign cnt_after = VW'(cnt) + VW'(byte_valid_i);
    // A completing byte already emits the full word, so flush adds nothing then.
    assign do_flush  = flush_i && !last && (cnt_after != '0);

    always_comb begin
        padded = merged;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (VW'(k) >= cnt_after) begin
                padded[8*k +: 8] = PAD_BYTE;
            end
        end
    end

    assign emit      = last || do_flush;
    assign emit_word = last ? merged : padded;
    assign emit_vb   = last ? VW'(WORD_BYTES) : cnt_after;
`else
    logic unused_flush;
    assign unused_flush = flush_i ^ (^PAD_BYTE);

    assign emit      = last;
    assign emit_word = merged;
    assign emit_vb   = VW'(WORD_BYTES);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt           <= '0;
            acc           <= '0;
            word_o        <= '0;
            word_en_o     <= 1'b0;
            valid_bytes_o <= '0;
        end else begin
            word_en_o <= emit;
            if (emit) begin
                word_o        <= emit_word;
                valid_bytes_o <= emit_vb;
                cnt           <= '0;
                acc           <= '0;
            end else if (byte_valid_i) begin
                acc <= merged;
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign fill_o = cnt;

endmodule
`default_nettype wire

// File: tb/tb_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_word_packer
// Brief    : Scoreboard bench for byte_word_packer (4-byte and 2-byte builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_word_packer;

    typedef struct {
        int          cyc;
        logic [31:0] w;
        logic [3:0]  vb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int passed = 0;

    // 4-byte instance
    logic [7:0]  b4 = '0;
    logic        v4 = 1'b0;
    logic        f4 = 1'b0;
    logic [31:0] word4;
    logic        en4;
    logic [2:0]  vb4;
    logic [1:0]  fill4;

    // 2-byte instance
    logic [7:0]  b2 = '0;
    logic        v2 = 1'b0;
    logic        f2 = 1'b0;
    logic [15:0] word2;
    logic        en2;
    logic [1:0]  vb2;
    logic        fill2;

    exp_t q4[$];
    exp_t q2[$];

    byte_word_packer #(.WORD_BYTES(4), .PAD_BYTE(8'hEE)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .byte_i(b4), .byte_valid_i(v4),
        .flush_i(f4), .word_o(word4), .word_en_o(en4),
        .valid_bytes_o(vb4), .fill_o(fill4)
    );

    byte_word_packer #(.WORD_BYTES(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .byte_i(b2), .byte_valid_i(v2),
        .flush_i(f2), .word_o(word2), .word_en_o(en2),
        .valid_bytes_o(vb2), .fill_o(fill2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive4(input logic v, input logic [7:0] b, input logic f);
        @(negedge clk);
        v4 = v; b4 = b; f4 = f;
    endtask

    task automatic drive2(input logic v, input logic [7:0] b, input logic f);
        @(negedge clk);
        v2 = v; b2 = b; f2 = f;
    endtask

    // Called in the same negedge slot as the final byte: pulse is due one edge later.
    task automatic exp4(input logic [31:0] w, input logic [3:0] vb);
        q4.push_back('{cyc: cyc + 1, w: w, vb: vb});
    endtask

    task automatic exp2(input logic [31:0] w, input logic [3:0] vb);
        q2.push_back('{cyc: cyc + 1, w: w, vb: vb});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (en4) begin
                if (q4.size() == 0) chk("u4_unexpected_pulse", 64'd1, 64'd0);
                else begin
                    e = q4.pop_front();
                    chk("u4_pulse_cycle", 64'(cyc), 64'(e.cyc));
                    chk("u4_word", 64'(word4), 64'(e.w));
                    chk("u4_valid_bytes", 64'(vb4), 64'(e.vb));
                end
            end else if (q4.size() > 0 && q4[0].cyc <= cyc) begin
                chk("u4_missing_pulse", 64'd0, 64'd1);
                void'(q4.pop_front());
            end
            if (en2) begin
                if (q2.size() == 0) chk("u2_unexpected_pulse", 64'd1, 64'd0);
                else begin
                    e = q2.pop_front();
                    chk("u2_pulse_cycle", 64'(cyc), 64'(e.cyc));
                    chk("u2_word", 64'(word2), 64'(e.w));
                    chk("u2_valid_bytes", 64'(vb2), 64'(e.vb));
                end
            end else if (q2.size() > 0 && q2[0].cyc <= cyc) begin
                chk("u2_missing_pulse", 64'd0, 64'd1);
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_word", 64'(word4), 64'h0);
        chk("rst_en", 64'(en4), 64'h0);
        chk("rst_vb", 64'(vb4), 64'h0);
        chk("rst_fill", 64'(fill4), 64'h0);
        rst_n = 1'b1;

        // Single word
        drive4(1, 8'h11, 0);
        drive4(1, 8'h22, 0);
        drive4(1, 8'h33, 0);
        drive4(1, 8'h44, 0); exp4(32'h44332211, 4);
        drive4(0, 8'h00, 0);
        chk("fill_after_word", 64'(fill4), 64'h0);

        // Continuous stream: two back-to-back words
        for (int i = 1; i <= 8; i++) begin
            drive4(1, 8'(i), 0);
            if (i == 4) exp4(32'h04030201, 4);
            if (i == 8) exp4(32'h08070605, 4);
        end
        repeat (3) drive4(0, 8'h00, 0);
        chk("hold_word", 64'(word4), 64'h08070605);
        chk("hold_en", 64'(en4), 64'h0);

        // Gapped input
        drive4(1, 8'hAA, 0);
        repeat (3) drive4(0, 8'h00, 0);
        drive4(1, 8'hBB, 0);
        repeat (3) drive4(0, 8'h00, 0);
        chk("gap_fill", 64'(fill4), 64'h2);
        drive4(1, 8'hCC, 0);
        drive4(1, 8'hDD, 0); exp4(32'hDDCCBBAA, 4);
        drive4(0, 8'h00, 0);

        // Flush with concurrent byte, then flush with nothing held
        drive4(1, 8'h01, 0);
        drive4(1, 8'h02, 0);
`ifdef BYTE_WORD_PACKER_FLUSH_EN
        drive4(1, 8'h03, 1); exp4(32'hEE030201, 3);
        drive4(0, 8'h00, 1);
        drive4(0, 8'h00, 0);
        chk("flush_fill", 64'(fill4), 64'h0);
        drive4(1, 8'h07, 0);
        drive4(0, 8'h00, 1); exp4(32'hEEEEEE07, 1);
        drive4(0, 8'h00, 0);
`else
        drive4(1, 8'h03, 1);
        drive4(0, 8'h00, 1);
        drive4(0, 8'h00, 0);
        chk("noflush_fill", 64'(fill4), 64'h3);
        drive4(1, 8'h04, 0); exp4(32'h04030201, 4);
        drive4(0, 8'h00, 0);
`endif
        repeat (2) drive4(0, 8'h00, 0);

        // Mid-word asynchronous reset
        drive4(1, 8'h10, 0);
        drive4(1, 8'h20, 0);
        @(posedge clk);
        v4 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_word", 64'(word4), 64'h0);
        chk("async_rst_en", 64'(en4), 64'h0);
        chk("async_rst_vb", 64'(vb4), 64'h0);
        chk("async_rst_fill", 64'(fill4), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive4(1, 8'h50, 0);
        drive4(1, 8'h51, 0);
        drive4(1, 8'h52, 0);
        drive4(1, 8'h53, 0); exp4(32'h53525150, 4);
        drive4(0, 8'h00, 0);

        // Two-byte instance
        drive2(1, 8'hAB, 0);
        drive2(1, 8'hCD, 0); exp2(32'h0000CDAB, 2);
        drive2(0, 8'h00, 1);
        drive2(0, 8'h00, 0);
        chk("u2_fill", 64'(fill2), 64'h0);
`ifdef BYTE_WORD_PACKER_FLUSH_EN
        drive2(1, 8'hEF, 1); exp2(32'h000000EF, 1);
        drive2(0, 8'h00, 0);
`else
        drive2(1, 8'hEF, 1);
        drive2(0, 8'h00, 0);
        chk("u2_noflush_fill", 64'(fill2), 64'h1);
`endif

        repeat (4) @(negedge clk);
        chk("u4_queue_drained", 64'(q4.size()), 64'h0);
        chk("u2_queue_drained", 64'(q2.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_word_packer.md
# byte_word_packer

Upstream stage for the 32-bit enabled register: it assembles a byte stream into little-endian words and emits each completed word with a one-cycle enable pulse. `word_o`/`word_en_o` connect directly to the register's `data_i`/`en_i`. `rst_ni` is the block's own reset and is not derived from the register's reset. An optional flush path pads and emits a partial word.

## Interface
- `WORD_BYTES`, default 4: bytes per word; legal range 2..8.
- `PAD_BYTE`, default 8'h00: value placed in unfilled lanes on flush.
- `clk_i`  in  1: clock; all logic on the rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `byte_i`  in  8: input byte.
- `byte_valid_i`  in  1: when high, `byte_i` is accepted this cycle; always accepted, no backpressure.
- `flush_i`  in  1: request to emit the partial word (see Configuration).
- `word_o`  out  8*WORD_BYTES: last emitted word; held between emissions.
- `word_en_o`  out  1: one-cycle pulse, high in the cycle `word_o` carries a newly emitted word.
- `valid_bytes_o`  out  $clog2(WORD_BYTES+1): real (non-pad) byte count of the last emitted word.
- `fill_o`  out  $clog2(WORD_BYTES): current lane index, equal to the number of bytes held in the accumulator.

## Operation
- State: lane counter `cnt` (0..WORD_BYTES-1) and accumulator `acc[8*WORD_BYTES-1:0]`.
- Lane order is little-endian: the first byte of a word lands in bits [7:0]; lane k is bits [8k+7:8k].
- Accepted byte with `cnt < WORD_BYTES-1`:
  - `acc` lane `cnt` <= `byte_i`
  - `cnt` <= `cnt`+1
  - no emission.
- Accepted byte with `cnt == WORD_BYTES-1` (word complete):
  - `word_o` <= `acc` with lane `cnt` replaced by `byte_i`
  - `word_en_o` <= 1
  - `valid_bytes_o` <= WORD_BYTES
  - `cnt` <= 0
  - `acc` <= 0.
- `word_en_o` is 0 in every cycle with no emission. Back-to-back emissions (every WORD_BYTES cycles) produce back-to-back pulses, each exactly one cycle wide.
- `fill_o` = `cnt`, driven combinationally from the register.
- Async reset (`rst_ni` low), applied immediately and held while low:
  - `word_o`, `acc`: 0
  - `cnt`: 0
  - `word_en_o`: 0
  - `valid_bytes_o`: 0.
- A partial word present at reset is discarded and never emitted.

## Timing
- Latency: `word_en_o` and the new `word_o` appear on the clock edge that accepts the final byte, i.e. registered and visible in the following cycle. The downstream register captures on the edge after that.
- Throughput: one byte per cycle, sustained indefinitely.
- `cnt` wraps WORD_BYTES-1 -> 0 only on emission; there is no overflow condition.
- Reset release: the first accepted byte after `rst_ni` rises goes to lane 0.
- `byte_valid_i` low: `cnt`, `acc` and `word_o` hold; `word_en_o` is 0.

## Configuration
- Macro: `BYTE_WORD_PACKER_FLUSH_EN`.
- Defined:
  - `flush_i` high with `cnt` > 0 after this cycle's byte (if any) is applied: emit a partial word.
    - Lanes already filled keep their data; the remaining lanes are `PAD_BYTE`.
    - `valid_bytes_o` = number of real bytes.
    - `word_en_o` pulses; `cnt` <= 0; `acc` <= 0.
  - Byte and flush in the same cycle: the byte is written first. If that byte completes the word, the result is a normal full emission and the flush adds nothing. Otherwise the emitted word includes that byte.
  - Flush with `cnt == 0` and no byte: no effect, no pulse.
- Not defined:
  - `flush_i` is ignored and no flush logic is synthesized.
  - `valid_bytes_o` is always WORD_BYTES after the first emission, 0 before it.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> single-cycle `word_en_o`; `word_o`=0x44332211; `valid_bytes_o`=4; `fill_o` returns to 0.
- 8 continuous bytes 0x01..0x08 -> two pulses 4 cycles apart; `word_o`=0x04030201, then 0x08070605; `word_o` holds 0x08070605 afterwards.
- Bytes 0xAA,0xBB with `byte_valid_i` gaps of 3 idle cycles between them, then 0xCC,0xDD -> one pulse after 0xDD; `word_o`=0xDDCCBBAA; no pulse earlier.
- FLUSH_EN, PAD_BYTE=8'hEE: bytes 0x01,0x02, then flush_i together with byte 0x03 -> `word_o`=0xEE030201, `valid_bytes_o`=3. A following flush with no bytes -> no pulse.
- Bytes 0x10,0x20, then `rst_ni` low mid-cycle -> outputs 0 asynchronously. After release, bytes 0x50..0x53 -> `word_o`=0x53525150 (no stale lanes).
- WORD_BYTES=2: bytes 0xAB,0xCD -> `word_o`=0xCDAB, `valid_bytes_o`=2; flush with `cnt`=0 -> no pulse.
